// File: rtl/fetch_pair_buffer.sv
// fetch_pair_buffer: circular queue of fetched instruction pairs between fetch and decode; optional macro FETCH_BUF_BYPASS_EN adds an empty-buffer zero-cycle path
module fetch_pair_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [31:0]              instr1_i,
    input  logic [31:0]              instr2_i,
    input  logic [31:0]              pc_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    output logic [31:0]              instr1_o,
    output logic [31:0]              instr2_o,
    output logic [31:0]              PCD_o,
    output logic [31:0]              PCD_2_o,
    output logic [31:0]              PCPlus4D_o,
    output logic [31:0]              PCPlus4D_2_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_instr1 [DEPTH];
    logic [31:0]   r_instr2 [DEPTH];
    logic [31:0]   r_pc     [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_byp;
    logic          w_push;
    logic          w_pop;
    logic          w_wr;
    logic          w_rd;
    logic [31:0]   w_i1;
    logic [31:0]   w_i2;
    logic [31:0]   w_pc;

`ifdef FETCH_BUF_BYPASS_EN
    assign w_byp = (r_count == '0) && push_valid_i && !flush_i && !rst_i;
`else
    assign w_byp = 1'b0;
`endif

    assign push_ready_o = (r_count != CW'(DEPTH));
    assign valid_o      = (r_count != '0) || w_byp;
    assign count_o      = r_count;
    assign w_push       = push_valid_i && push_ready_o && !flush_i;
    assign w_pop        = pop_i && valid_o && !flush_i;
    // A bypassed pair consumed in the same cycle never lands in storage, and the stored head is untouched
    assign w_wr         = w_push && !(w_byp && pop_i);
    assign w_rd         = w_pop && !w_byp;

    assign w_i1 = w_byp ? instr1_i : r_instr1[r_rptr];
    assign w_i2 = w_byp ? instr2_i : r_instr2[r_rptr];
    assign w_pc = w_byp ? pc_i     : r_pc[r_rptr];

    assign instr1_o     = valid_o ? w_i1 : '0;
    assign instr2_o     = valid_o ? w_i2 : '0;
    assign PCD_o        = valid_o ? w_pc : '0;
    assign PCD_2_o      = valid_o ? w_pc + 32'd4 : '0;
    assign PCPlus4D_o   = valid_o ? w_pc + 32'd4 : '0;
    assign PCPlus4D_2_o = valid_o ? w_pc + 32'd8 : '0;

    // Storage array; contents survive reset and flush since count gates visibility
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_instr1[r_wptr] <= instr1_i;
            r_instr2[r_wptr] <= instr2_i;
            r_pc[r_wptr]     <= pc_i;
        end
    end

    // Pointer and occupancy tracking; flush outranks any same-cycle push or pop
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_wr ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_rd ? r_rptr + 1'b1 : r_rptr;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end
endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb_fetch_pair_buffer: queue-model and directed checks for fetch_pair_buffer
module tb_fetch_pair_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] i1;
        logic [31:0] i2;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 0;
    logic        rst_i = 1;
    logic        push_valid_i = 0;
    logic        push_ready_o;
    logic [31:0] instr1_i = 0;
    logic [31:0] instr2_i = 0;
    logic [31:0] pc_i = 0;
    logic        pop_i = 0;
    logic        flush_i = 0;
    logic        valid_o;
    logic [31:0] instr1_o, instr2_o, PCD_o, PCD_2_o, PCPlus4D_o, PCPlus4D_2_o;
    logic [$clog2(DEPTH):0] count_o;

    int n_chk = 0;
    int n_fail = 0;
    ent_t q[$];

    fetch_pair_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_i(rst_i), .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .instr1_i(instr1_i), .instr2_i(instr2_i), .pc_i(pc_i), .pop_i(pop_i), .flush_i(flush_i),
        .valid_o(valid_o), .instr1_o(instr1_o), .instr2_o(instr2_o), .PCD_o(PCD_o),
        .PCD_2_o(PCD_2_o), .PCPlus4D_o(PCPlus4D_o), .PCPlus4D_2_o(PCPlus4D_2_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic model_byp();
`ifdef FETCH_BUF_BYPASS_EN
        return q.size() == 0 && push_valid_i && !flush_i && !rst_i;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst_i) begin
        if (rst_i || flush_i) q.delete();
        else begin
            int   sz;
            logic byp, pop, push;
            sz   = q.size();
            byp  = model_byp();
            pop  = pop_i && (sz > 0 || byp);
            push = push_valid_i && sz < DEPTH;
            if (!(byp && pop)) begin
                if (pop && sz > 0) void'(q.pop_front());
                if (push) q.push_back('{instr1_i, instr2_i, pc_i});
            end
        end
    end

    always @(negedge clk) begin
        ent_t h;
        logic byp, v;
        byp = model_byp();
        v   = q.size() != 0 || byp;
        h   = byp ? ent_t'({instr1_i, instr2_i, pc_i}) : (q.size() != 0 ? q[0] : ent_t'('0));
        if (!v) h = '0;
        chk("m_count", 32'(count_o), 32'(q.size()));
        chk("m_ready", 32'(push_ready_o), 32'(q.size() < DEPTH));
        chk("m_valid", 32'(valid_o), 32'(v));
        chk("m_instr1", instr1_o, h.i1);
        chk("m_instr2", instr2_o, h.i2);
        chk("m_pcd", PCD_o, h.pc);
        chk("m_pcd2", PCD_2_o, v ? h.pc + 32'd4 : 32'd0);
        chk("m_pc4", PCPlus4D_o, v ? h.pc + 32'd4 : 32'd0);
        chk("m_pc4_2", PCPlus4D_2_o, v ? h.pc + 32'd8 : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        push_valid_i = 1;
        pc_i = pc;
        instr1_i = pc ^ 32'h00500093;
        instr2_i = pc ^ 32'h00A00113;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_ready", 32'(push_ready_o), 1);
        chk("rst_valid", 32'(valid_o), 0);
        rst_i = 0;
        step();
        push_valid_i = 1; instr1_i = 32'h00500093; instr2_i = 32'h00A00113; pc_i = 32'h100;
        step();
        push_valid_i = 0;
        @(negedge clk);
        chk("p1_valid", 32'(valid_o), 1);
        chk("p1_instr1", instr1_o, 32'h00500093);
        chk("p1_instr2", instr2_o, 32'h00A00113);
        chk("p1_pcd", PCD_o, 32'h100);
        chk("p1_pcd2", PCD_2_o, 32'h104);
        chk("p1_pc4", PCPlus4D_o, 32'h104);
        chk("p1_pc4_2", PCPlus4D_2_o, 32'h108);
        chk("p1_count", 32'(count_o), 1);
        pop_i = 1; step(); pop_i = 0;
        for (int k = 0; k < 5; k++) begin
            push(32'(k * 8));
            step();
        end
        push_valid_i = 0;
        @(negedge clk);
        chk("full_count", 32'(count_o), 4);
        chk("full_ready", 32'(push_ready_o), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("order_pcd", PCD_o, 32'(k * 8));
            pop_i = 1; step(); pop_i = 0;
        end
        @(negedge clk);
        chk("drained_count", 32'(count_o), 0);
        for (int k = 0; k < 3; k++) begin
            push(32'h300 + 32'(k * 8));
            step();
        end
        for (int k = 0; k < 8; k++) begin
            push(32'h318 + 32'(k * 8));
            pop_i = 1;
            step();
            push_valid_i = 0; pop_i = 0;
            @(negedge clk);
            chk("pp_count", 32'(count_o), 3);
            chk("pp_head", PCD_o, 32'h300 + 32'((k + 1) * 8));
        end
        pop_i = 1; step();
        @(negedge clk);
        chk("pre_flush_count", 32'(count_o), 2);
        push(32'h3F0); flush_i = 1;
        step();
        push_valid_i = 0; pop_i = 0; flush_i = 0;
        @(negedge clk);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_valid", 32'(valid_o), 0);
        chk("flush_pcd", PCD_o, 0);
        chk("flush_instr1", instr1_o, 0);
        chk("flush_pc4_2", PCPlus4D_2_o, 0);
        push(32'h400); step();
        push(32'h408); step();
        push_valid_i = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("stall_pcd", PCD_o, 32'h400);
            chk("stall_instr2", instr2_o, 32'h400 ^ 32'h00A00113);
        end
        step();
        push(32'h410); rst_i = 1;
        #2;
        chk("arst_count", 32'(count_o), 0);
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_pcd", PCD_o, 0);
        chk("arst_ready", 32'(push_ready_o), 1);
        step(); step();
        rst_i = 0;
        push(32'h500);
        step();
        push_valid_i = 0;
        @(negedge clk);
        chk("resume_count", 32'(count_o), 1);
        chk("resume_pcd", PCD_o, 32'h500);
        pop_i = 1; step(); pop_i = 0;
`ifdef FETCH_BUF_BYPASS_EN
        push(32'h200); pop_i = 1;
        #2;
        chk("byp_valid", 32'(valid_o), 1);
        chk("byp_pcd", PCD_o, 32'h200);
        step();
        push_valid_i = 0; pop_i = 0;
        @(negedge clk);
        chk("byp_count", 32'(count_o), 0);
        chk("byp_valid_after", 32'(valid_o), 0);
`endif
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
